// File: rtl/lcd_pattern_source.sv
// lcd_pattern_source
//   Command/pixel source for an ST7789 panel behind a 9-bit SPI FIFO.
//   Sequence: hardware reset hold, power-up wait, SLPOUT, sleep-out wait,
//   init table, then an endless loop of {window setup, one frame of pixels}.
//   Each FIFO word is {D/C, byte}: bit 8 = 0 for commands, 1 for data.
//
// Handshake: a word moves on any cycle with fifo_write_valid and
//   fifo_write_ready both high. valid/data are decoded from registered state
//   only, and that state advances only on a transfer, so an offered word
//   stays stable until it is taken. With ready held high one word moves per
//   cycle, including across state changes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mode[1:0]           0 h-bars, 1 v-bars, 2 8x8 checkerboard, 3 solid
//   solid_color[15:0]   RGB565 colour for mode 3
//   fifo_write_valid    word offered
//   fifo_write_data[8:0]{D/C, byte}
//   fifo_write_ready    FIFO accepts the word
//   lcd_resetn          panel hardware reset, active low
//   init_done           set once the first RAMWR is taken
//   frame_done          one-cycle pulse after the last pixel byte is taken
//   dbg_state[2:0]      current FSM state encoding
module lcd_pattern_source #(
  parameter int CLK_HZ     = 27000000,
  parameter int LCD_WIDTH  = 240,
  parameter int LCD_HEIGHT = 135,
  parameter int X_OFFSET   = 40,
  parameter int Y_OFFSET   = 53,
  parameter int NUM_BARS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        fifo_write_valid,
  output logic [8:0]  fifo_write_data,
  input  logic        fifo_write_ready,
  output logic        lcd_resetn,
  output logic        init_done,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  localparam int D100 = CLK_HZ / 10;
  localparam int D200 = CLK_HZ / 5;
  localparam int D120 = CLK_HZ * 12 / 100;

  localparam logic [15:0] XS = 16'(X_OFFSET);
  localparam logic [15:0] XE = 16'(X_OFFSET + LCD_WIDTH - 1);
  localparam logic [15:0] YS = 16'(Y_OFFSET);
  localparam logic [15:0] YE = 16'(Y_OFFSET + LCD_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD, S_POWER_WAIT, S_SLPOUT, S_SLEEP_WAIT, S_INIT, S_WINDOW, S_PIXELS
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt;
  logic [15:0] x_cnt, y_cnt;
  logic        lo_byte;
  logic [15:0] acc_x, acc_y;
  logic [4:0]  bar_x, bar_y;
  logic [1:0]  mode_q;
  logic [15:0] solid_q;
  logic [15:0] color;
  logic [20:0] step_x, step_y;
  logic        fire, last_x, last_y, delay_state;

  assign dbg_state = state;
  assign fire      = fifo_write_valid & fifo_write_ready;
  assign last_x    = (x_cnt == 16'(LCD_WIDTH - 1));
  assign last_y    = (y_cnt == 16'(LCD_HEIGHT - 1));
  assign delay_state = (state == S_RESET_HOLD) || (state == S_POWER_WAIT) ||
                       (state == S_SLEEP_WAIT);

  function automatic logic [8:0] init_word(input logic [5:0] i);
    case (i)
      6'd0:  return 9'h036; 6'd1:  return 9'h170; 6'd2:  return 9'h03A; 6'd3:  return 9'h105;
      6'd4:  return 9'h0B2; 6'd5:  return 9'h10C; 6'd6:  return 9'h10C; 6'd7:  return 9'h100;
      6'd8:  return 9'h133; 6'd9:  return 9'h133; 6'd10: return 9'h0B7; 6'd11: return 9'h135;
      6'd12: return 9'h0BB; 6'd13: return 9'h119; 6'd14: return 9'h0C0; 6'd15: return 9'h12C;
      6'd16: return 9'h0C2; 6'd17: return 9'h101; 6'd18: return 9'h0C3; 6'd19: return 9'h112;
      6'd20: return 9'h0C4; 6'd21: return 9'h120; 6'd22: return 9'h0C6; 6'd23: return 9'h10F;
      6'd24: return 9'h0D0; 6'd25: return 9'h1A4; 6'd26: return 9'h1A1; 6'd27: return 9'h0E0;
      6'd28: return 9'h1D0; 6'd29: return 9'h104; 6'd30: return 9'h10D; 6'd31: return 9'h111;
      6'd32: return 9'h113; 6'd33: return 9'h12B; 6'd34: return 9'h13F; 6'd35: return 9'h154;
      6'd36: return 9'h14C; 6'd37: return 9'h118; 6'd38: return 9'h10D; 6'd39: return 9'h10B;
      6'd40: return 9'h11F; 6'd41: return 9'h123; 6'd42: return 9'h0E1; 6'd43: return 9'h1D0;
      6'd44: return 9'h104; 6'd45: return 9'h10C; 6'd46: return 9'h111; 6'd47: return 9'h113;
      6'd48: return 9'h12C; 6'd49: return 9'h13F; 6'd50: return 9'h144; 6'd51: return 9'h151;
      6'd52: return 9'h12F; 6'd53: return 9'h11F; 6'd54: return 9'h11F; 6'd55: return 9'h120;
      6'd56: return 9'h123; 6'd57: return 9'h021; 6'd58: return 9'h029;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] window_word(input logic [3:0] i);
    case (i)
      4'd0:  return 9'h02A;
      4'd1:  return {1'b1, XS[15:8]};
      4'd2:  return {1'b1, XS[7:0]};
      4'd3:  return {1'b1, XE[15:8]};
      4'd4:  return {1'b1, XE[7:0]};
      4'd5:  return 9'h02B;
      4'd6:  return {1'b1, YS[15:8]};
      4'd7:  return {1'b1, YS[7:0]};
      4'd8:  return {1'b1, YE[15:8]};
      4'd9:  return {1'b1, YE[7:0]};
      4'd10: return 9'h02C;
      default: return 9'h000;
    endcase
  endfunction

  // Advance a bar accumulator by one coordinate step: acc holds
  // (coord*NUM_BARS) mod span and bar holds the quotient. When span is
  // smaller than NUM_BARS one step can cross several bars, so up to
  // NUM_BARS subtractions are unrolled.
  function automatic logic [20:0] bar_step(input logic [15:0] acc, input logic [4:0] bar,
                                           input logic [16:0] span);
    logic [16:0] tmp;
    logic [4:0]  b;
    tmp = {1'b0, acc} + 17'(NUM_BARS);
    b   = bar;
    for (int i = 0; i < NUM_BARS; i++) begin
      if (tmp >= span) begin
        tmp = tmp - span;
        b   = b + 5'd1;
      end
    end
    return {b, tmp[15:0]};
  endfunction

  always_comb begin
    step_x = bar_step(acc_x, bar_x, 17'(LCD_WIDTH));
    step_y = bar_step(acc_y, bar_y, 17'(LCD_HEIGHT));
  end

  function automatic logic [15:0] palette(input logic [1:0] b);
    case (b)
      2'd0:    return 16'h001F;
      2'd1:    return 16'h07E0;
      2'd2:    return 16'hF800;
      default: return 16'hFFFF;
    endcase
  endfunction

  always_comb begin
    color = solid_q;
    case (mode_q)
      2'd0:    color = palette(bar_y[1:0]);
      2'd1:    color = palette(bar_x[1:0]);
      2'd2:    color = (x_cnt[3] ^ y_cnt[3]) ? 16'hFFFF : 16'h0000;
      default: color = solid_q;
    endcase
  end

  // Next state and outputs; everything decodes from registered state.
  always_comb begin
    state_nx         = state;
    fifo_write_valid = 1'b0;
    fifo_write_data  = 9'h000;
    lcd_resetn       = 1'b1;
    case (state)
      S_RESET_HOLD: begin
        lcd_resetn = 1'b0;
        if (cnt == 32'(D100 - 1)) state_nx = S_POWER_WAIT;
      end
      S_POWER_WAIT: if (cnt == 32'(D200 - 1)) state_nx = S_SLPOUT;
      S_SLPOUT: begin
        fifo_write_valid = 1'b1;
        fifo_write_data  = 9'h011;
        if (fifo_write_ready) state_nx = S_SLEEP_WAIT;
      end
      S_SLEEP_WAIT: if (cnt == 32'(D120 - 1)) state_nx = S_INIT;
      S_INIT: begin
        fifo_write_valid = 1'b1;
        fifo_write_data  = init_word(cnt[5:0]);
        if (fifo_write_ready && cnt == 32'd58) state_nx = S_WINDOW;
      end
      S_WINDOW: begin
        fifo_write_valid = 1'b1;
        fifo_write_data  = window_word(cnt[3:0]);
        if (fifo_write_ready && cnt == 32'd10) state_nx = S_PIXELS;
      end
      S_PIXELS: begin
        fifo_write_valid = 1'b1;
        fifo_write_data  = {1'b1, lo_byte ? color[7:0] : color[15:8]};
        if (fifo_write_ready && lo_byte && last_x && last_y) state_nx = S_WINDOW;
      end
      default: state_nx = S_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RESET_HOLD;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      lo_byte    <= 1'b0;
      acc_x      <= '0;
      acc_y      <= '0;
      bar_x      <= '0;
      bar_y      <= '0;
      mode_q     <= '0;
      solid_q    <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_nx != state)
        cnt <= '0;
      else if (delay_state || (fire && (state == S_INIT || state == S_WINDOW)))
        cnt <= cnt + 32'd1;

      // RAMWR taken: latch the frame's pattern and rewind the pixel walk.
      if (fire && state == S_WINDOW && cnt == 32'd10) begin
        init_done <= 1'b1;
        mode_q    <= mode;
        solid_q   <= solid_color;
        x_cnt     <= '0;
        y_cnt     <= '0;
        lo_byte   <= 1'b0;
        acc_x     <= '0;
        acc_y     <= '0;
        bar_x     <= '0;
        bar_y     <= '0;
      end

      if (fire && state == S_PIXELS) begin
        lo_byte <= ~lo_byte;
        if (lo_byte) begin
          if (last_x) begin
            x_cnt <= '0;
            acc_x <= '0;
            bar_x <= '0;
            y_cnt <= y_cnt + 16'd1;
            {bar_y, acc_y} <= step_y;
            if (last_y) frame_done <= 1'b1;
          end else begin
            x_cnt <= x_cnt + 16'd1;
            {bar_x, acc_x} <= step_x;
          end
        end
      end
    end
  end

endmodule

// File: doc/lcd_pattern_source.md
# lcd_pattern_source

Parametrised command/pixel source for the ST7789 SPI LCD path. It drives the panel's hardware reset and power-up delays, sends the sleep-out command and the init table, then streams an endless sequence of frames into the 9-bit SPI FIFO. Each FIFO word carries the D/C flag in bit 8 (0 = command, 1 = data). Panel geometry, RAM window offsets, clock rate and bar count are parameters. The test pattern is run-time selectable and latched per frame.

## Interface
- CLK_HZ, 27000000: clock frequency. Delay counts are D100 = CLK_HZ/10, D200 = CLK_HZ/5 and D120 = CLK_HZ*12/100 cycles.
- LCD_WIDTH, 240: visible columns.
- LCD_HEIGHT, 135: visible rows.
- X_OFFSET, 40: first panel RAM column of the window.
- Y_OFFSET, 53: first panel RAM row of the window.
- NUM_BARS, 3: number of bars in the bar modes (1..16).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  pattern select: 0 = horizontal bars, 1 = vertical bars, 2 = 8x8 checkerboard, 3 = solid.
- solid_color  in  16  RGB565 colour used in mode 3.
- fifo_write_valid  out  1  FIFO word valid.
- fifo_write_data  out  9  {D/C, byte}.
- fifo_write_ready  in  1  FIFO can accept a word.
- lcd_resetn  out  1  panel hardware reset, active low.
- init_done  out  1  high from acceptance of the first RAMWR until the next reset.
- frame_done  out  1  one-cycle pulse when the last pixel byte of a frame is accepted.

## Operation
- Handshake: a word transfers on any cycle where valid and ready are both 1. Once valid is raised, it and the data stay stable until accepted. With ready held at 1, the block sends one word per cycle with no bubbles, including across state boundaries.
- States and transitions:
  - RESET_HOLD: lcd_resetn = 0 for D100 cycles.
  - POWER_WAIT: lcd_resetn = 1, wait D200 cycles.
  - SLPOUT: send 0x011.
  - SLEEP_WAIT: wait D120 cycles after 0x011 is accepted.
  - INIT: send the 59-word table.
  - WINDOW: send 11 words.
  - PIXELS: send 2*LCD_WIDTH*LCD_HEIGHT words.
  - After the last pixel byte, return to WINDOW, forever.
- Init table, in order; commands have bit8 = 0, data bytes have bit8 = 1:
  - 36 70; 3A 05; B2 0C 0C 00 33 33; B7 35; BB 19; C0 2C; C2 01; C3 12; C4 20; C6 0F; D0 A4 A1.
  - E0 D0 04 0D 11 13 2B 3F 54 4C 18 0D 0B 1F 23.
  - E1 D0 04 0C 11 13 2C 3F 44 51 2F 1F 1F 20 23.
  - 21; 29.
- Window words:
  - 0x02A, then XS[15:8], XS[7:0], XE[15:8], XE[7:0] as data, with XS = X_OFFSET and XE = X_OFFSET+LCD_WIDTH-1.
  - 0x02B, then the same four-byte form for YS = Y_OFFSET and YE = Y_OFFSET+LCD_HEIGHT-1.
  - 0x02C (RAMWR).
  - Offsets are computed at elaboration to 16 bits.
- Pixel order is row-major: x runs 0..LCD_WIDTH-1 fastest, then y runs 0..LCD_HEIGHT-1. Each pixel is sent as the high byte then the low byte, both with bit8 = 1.
- Colour:
  - Bar index b: in mode 0, b = floor(y*NUM_BARS/LCD_HEIGHT); in mode 1, b = floor(x*NUM_BARS/LCD_WIDTH). Palette[b mod 4] = 001F, 07E0, F800, FFFF.
  - Mode 2: ((x>>3)^(y>>3))&1 gives FFFF when 1, 0000 when 0.
  - Mode 3: solid_color.
  - Bar indices are produced by incremental accumulators, with no runtime dividers.
- mode and solid_color are sampled on the cycle RAMWR is accepted and held for the whole frame. Changes during a frame take effect on the next frame.

## Timing
- Reset values, applied immediately and asynchronously on rst:
  - lcd_resetn = 0, fifo_write_valid = 0, fifo_write_data = 0, init_done = 0, frame_done = 0.
  - All counters are 0 and the state is RESET_HOLD.
  - A reset mid-frame abandons the frame with no further words, and the full power-up sequence restarts.
- lcd_resetn rises exactly D100 cycles after rst deasserts.
- valid with 0x011 asserts exactly D200 cycles after lcd_resetn rises. Delay counters ignore ready.
- SLEEP_WAIT is exactly D120 cycles with valid = 0. INIT word 0 is presented on the next cycle.
- init_done rises on the cycle after RAMWR is accepted.
- frame_done is high on the cycle after the last low byte is accepted. In that same cycle the first WINDOW word (0x02A) is already presented.
- Ready deasserted mid-pixel (between high and low byte): hold the low byte; no duplication or skip.
- A ready toggle every cycle must still deliver every word exactly once, in order.

## Test plan
- Reset/power-up: CLK_HZ=1000, ready=1 -> lcd_resetn low for 100 cycles; 0x011 presented 200 cycles after lcd_resetn rises; 120 idle cycles; then 0x036, 0x170, 0x03A, 0x105 back to back.
- Window words: LCD_WIDTH=8, LCD_HEIGHT=4, mode=3, solid_color=0x1234 -> after the init table, 02A 100 128 100 12F 02B 100 135 100 138 02C, then 32 repetitions of 112 134, frame_done pulse, then 02A again.
- Bars: 8x4 panel, NUM_BARS=2. Mode 0 -> rows 0-1 0x001F, rows 2-3 0x07E0. Mode 1 -> columns 0-3 0x001F, columns 4-7 0x07E0.
- Checkerboard: 16x16 panel, mode 2 -> pixel (0,0)=0000, (8,0)=FFFF, (8,8)=0000, (0,15)=FFFF.
- Backpressure and latching: random ready at 50%, mode changed mid-frame -> stream identical word-for-word to the ready=1 stream; the new mode takes effect only after the next 0x02C.
- Reset mid-frame: assert rst during PIXELS -> same cycle valid=0, lcd_resetn=0, init_done=0; full sequence restarts from RESET_HOLD.
